// File: rtl/spi_slave_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_slave_wb
// Description : SPI mode-0 slave (MSB first) with a Wishbone register port.
//               SPI pins are oversampled on clk_24m through SYNC_LEN flops.
//               Registers: 0 RX data, 1 TX data, 2 STATUS, 3 reserved.
//               Optional feature macro: SPI_SLAVE_OVERRUN_EN (sticky overrun
//               flag and saturating overrun counter in STATUS).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_wb #(
    parameter int SYNC_LEN = 2
) (
    input  logic        clk_24m,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [1:0]  wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack
);

    localparam logic [1:0] c_ADDR_RX   = 2'd0;
    localparam logic [1:0] c_ADDR_TX   = 2'd1;
    localparam logic [1:0] c_ADDR_STAT = 2'd2;
    localparam logic [7:0] c_IDLE_BYTE = 8'hFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Synchronizers and edge-detect history
    logic [SYNC_LEN-1:0] r_sck_sync;
    logic [SYNC_LEN-1:0] r_mosi_sync;
    logic [SYNC_LEN-1:0] r_cs_sync;
    logic                r_sck_d;
    logic                r_cs_d;
    logic                r_armed;

    // Shift engine
    state_t              r_state;
    logic [2:0]          r_bit_cnt;
    logic [6:0]          r_rx_shift;
    logic [7:0]          r_tx_shift;
    logic                r_miso_oe;

    // Host-visible registers
    logic [7:0]          r_tx_hold;
    logic                r_tx_full;
    logic [7:0]          r_rx_data;
    logic                r_rx_valid;
    logic                r_ack;
    logic [31:0]         r_rdata;

    logic                w_sck_s;
    logic                w_mosi_s;
    logic                w_cs_s;
    logic                w_sck_rise;
    logic                w_sck_fall;
    logic                w_cs_fall;
    logic                w_start;
    logic                w_byte_done;
    logic                w_tx_load;
    logic [7:0]          w_tx_next;
    logic [7:0]          w_rx_byte;
    logic                w_acc;
    logic                w_rd_rx;
    logic                w_wr_tx;
    logic                w_wr_stat;
    logic                w_drop;
    logic                w_overrun;
    logic [7:0]          w_ovr_cnt;
    logic [31:0]         w_rd_mux;

    assign w_sck_s    = r_sck_sync[SYNC_LEN-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_LEN-1];
    assign w_cs_s     = r_cs_sync[SYNC_LEN-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_cs_fall  = r_cs_d & ~w_cs_s;

    // A frame only starts from a CS fall seen after CS was observed high,
    // so a frame already in progress at reset release is ignored.
    assign w_start     = (r_state == IDLE) & w_cs_fall & r_armed;
    assign w_byte_done = (r_state == XFER) & ~w_cs_s & w_sck_rise & (r_bit_cnt == 3'd7);
    assign w_tx_load   = w_start | w_byte_done;
    assign w_tx_next   = r_tx_full ? r_tx_hold : c_IDLE_BYTE;
    assign w_rx_byte   = {r_rx_shift, w_mosi_s};

    assign w_acc     = wb_cyc & ~r_ack;
    assign w_rd_rx   = w_acc & ~wb_we & (wb_addr == c_ADDR_RX);
    assign w_wr_tx   = w_acc & wb_we & (wb_addr == c_ADDR_TX);
    assign w_wr_stat = w_acc & wb_we & (wb_addr == c_ADDR_STAT) & wb_wdata[2];
    // A completing byte is dropped only if the held byte is not being read
    // in the same cycle; a simultaneous read frees the slot.
    assign w_drop    = w_byte_done & r_rx_valid & ~w_rd_rx;

    assign spi_miso    = r_tx_shift[7];
    assign spi_miso_oe = r_miso_oe;
    assign wb_ack      = r_ack;
    assign wb_rdata    = r_rdata;

    // Bring SPI pins into the clk_24m domain; CS chain resets low so that a
    // CS held low through reset never produces a falling edge.
    always_ff @(posedge clk_24m or posedge rst) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_LEN-2:0], spi_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_LEN-2:0], spi_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_LEN-2:0], spi_cs_n};
            r_sck_d     <= w_sck_s;
            r_cs_d      <= w_cs_s;
            if (w_cs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Frame state machine with the receive/transmit shift registers.
    always_ff @(posedge clk_24m or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= '0;
            r_tx_shift <= 8'hFF;
            r_miso_oe  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= XFER;
                        r_bit_cnt  <= 3'd0;
                        r_tx_shift <= w_tx_next;
                        r_miso_oe  <= 1'b1;
                    end
                end
                XFER: begin
                    if (w_cs_s) begin
                        // CS released: any partial byte is abandoned
                        r_state   <= IDLE;
                        r_bit_cnt <= 3'd0;
                        r_miso_oe <= 1'b0;
                    end else if (w_sck_rise) begin
                        r_rx_shift <= w_rx_byte[6:0];
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx_shift <= w_tx_next;
                        end
                    end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
                        // First bit of each byte is already on the pin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Wishbone handshake plus the TX holding and RX data registers.
    always_ff @(posedge clk_24m or posedge rst) begin
        if (rst) begin
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_tx_hold  <= '0;
            r_tx_full  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_ack   <= w_acc;
            r_rdata <= w_acc ? w_rd_mux : 32'd0;

            // The shifter loads from the pre-write value; a write in the
            // same cycle stays pending.
            if (w_wr_tx) begin
                r_tx_hold <= wb_wdata[7:0];
                r_tx_full <= 1'b1;
            end else if (w_tx_load) begin
                r_tx_full <= 1'b0;
            end

            if (w_byte_done && (!r_rx_valid || w_rd_rx)) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
            end else if (w_rd_rx) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic       r_overrun;
    logic [7:0] r_ovr_cnt;

    // Sticky overrun flag and saturating drop counter; a drop in the same
    // cycle as a clear is still recorded.
    always_ff @(posedge clk_24m or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (w_wr_stat) begin
                r_ovr_cnt <= 8'd1;
            end else if (r_ovr_cnt != 8'hFF) begin
                r_ovr_cnt <= r_ovr_cnt + 8'd1;
            end
        end else if (w_wr_stat) begin
            r_overrun <= 1'b0;
            r_ovr_cnt <= '0;
        end
    end

    assign w_overrun = r_overrun;
    assign w_ovr_cnt = r_ovr_cnt;
`else
    assign w_overrun = 1'b0;
    assign w_ovr_cnt = 8'd0;
`endif

    // Register read multiplexer, sampled into wb_rdata on the acked cycle.
    always_comb begin
        w_rd_mux = 32'd0;
        case (wb_addr)
            c_ADDR_RX:   w_rd_mux = {r_rx_valid, 23'd0, r_rx_data};
            c_ADDR_TX:   w_rd_mux = {r_tx_full, 23'd0, r_tx_hold};
            c_ADDR_STAT: w_rd_mux = {16'd0, w_ovr_cnt, 4'd0, (r_state == XFER),
                                     w_overrun, r_rx_valid, r_tx_full};
            default:     w_rd_mux = 32'd0;
        endcase
    end

    // Upper write-data bits have no register behind them; the drop/clear
    // strobes are only consumed when the overrun feature is built in.
    logic w_unused;
    assign w_unused = &{1'b0, wb_wdata[31:8], w_drop, w_wr_stat};

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_wb
// Description : Self-checking bench for spi_slave_wb. A behavioural SPI
//               master runs at 4 MHz (6 clk_24m cycles per bit); expected
//               MISO bytes are queued when the slave loads them and compared
//               when each byte completes. Register reads are compared with a
//               small behavioural model of the slave registers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_wb;

    localparam int SYNC_LEN = 2;

    logic        clk_24m = 1'b0;
    logic        rst     = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [1:0]  wb_addr = 2'd0;
    logic [31:0] wb_wdata = 32'd0;
    logic [31:0] wb_rdata;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard of bytes the slave is expected to shift out
    logic [7:0] q_miso[$];

    // Behavioural model of the host-visible state
    logic       mdl_tx_full;
    logic [7:0] mdl_tx_hold;
    logic       mdl_rx_valid;
    logic [7:0] mdl_rx_data;
    logic       mdl_ovr;
    int         mdl_ovr_cnt;

    always #20.833 clk_24m = ~clk_24m;

    spi_slave_wb #(.SYNC_LEN(SYNC_LEN)) dut (
        .clk_24m     (clk_24m),
        .rst         (rst),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .wb_addr     (wb_addr),
        .wb_wdata    (wb_wdata),
        .wb_rdata    (wb_rdata),
        .wb_we       (wb_we),
        .wb_cyc      (wb_cyc),
        .wb_ack      (wb_ack)
    );

    task automatic mdl_reset();
        mdl_tx_full  = 1'b0;
        mdl_tx_hold  = 8'h00;
        mdl_rx_valid = 1'b0;
        mdl_rx_data  = 8'h00;
        mdl_ovr      = 1'b0;
        mdl_ovr_cnt  = 0;
        q_miso.delete();
    endtask

    // Slave loads its shifter at CS fall and at every byte boundary
    task automatic mdl_load();
        q_miso.push_back(mdl_tx_full ? mdl_tx_hold : 8'hFF);
        mdl_tx_full = 1'b0;
    endtask

    function automatic logic [31:0] exp_rx();
        return {mdl_rx_valid, 23'd0, mdl_rx_data};
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'd0;
        s[0] = mdl_tx_full;
        s[1] = mdl_rx_valid;
`ifdef SPI_SLAVE_OVERRUN_EN
        s[2] = mdl_ovr;
        s[15:8] = mdl_ovr_cnt[7:0];
`endif
        return s;
    endfunction

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_24m);
        wb_addr = a;
        wb_we   = 1'b0;
        wb_cyc  = 1'b1;
        @(negedge clk_24m);
        n_checks++;
        if (wb_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL wb_rd_ack addr=%0d: got %b expected 1", a, wb_ack);
        end
        d = wb_rdata;
        wb_cyc = 1'b0;
        if (a == 2'd0) mdl_rx_valid = 1'b0;
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_24m);
        wb_addr  = a;
        wb_wdata = d;
        wb_we    = 1'b1;
        wb_cyc   = 1'b1;
        @(negedge clk_24m);
        n_checks++;
        if (wb_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL wb_wr_ack addr=%0d: got %b expected 1", a, wb_ack);
        end
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        if (a == 2'd1) begin
            mdl_tx_hold = d[7:0];
            mdl_tx_full = 1'b1;
        end
        if (a == 2'd2 && d[2]) begin
            mdl_ovr     = 1'b0;
            mdl_ovr_cnt = 0;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        mdl_load();
        repeat (4) @(negedge clk_24m);
        n_checks++;
        if (spi_miso_oe !== 1'b1) begin
            n_errors++;
            $display("FAIL cs_low_oe: got %b expected 1", spi_miso_oe);
        end
    endtask

    // Raise CS and require the pad enable to drop within SYNC_LEN+2 clocks
    task automatic cs_high();
        spi_cs_n = 1'b1;
        for (int k = 0; k < SYNC_LEN + 2; k++) begin
            @(negedge clk_24m);
            if (spi_miso_oe === 1'b0) break;
        end
        n_checks++;
        if (spi_miso_oe !== 1'b0) begin
            n_errors++;
            $display("FAIL cs_high_oe: got %b expected 0", spi_miso_oe);
        end
        q_miso.delete();
        repeat (4) @(negedge clk_24m);
    endtask

    // Clock n bits of a byte without checking MISO (aborted/ignored frames)
    task automatic spi_bits(input logic [7:0] tx, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            repeat (4) @(negedge clk_24m);
            spi_sck = 1'b1;
            repeat (2) @(negedge clk_24m);
            spi_sck = 1'b0;
        end
    endtask

    // Full byte; with rd_hit an RX read is acked on the byte-complete cycle
    task automatic spi_byte(input logic [7:0] tx, input logic rd_hit,
                            output logic [31:0] hit_data);
        logic [7:0] got;
        logic [7:0] exp;
        hit_data = 32'd0;
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (4) @(negedge clk_24m);
            got[i] = spi_miso;
            spi_sck = 1'b1;
            repeat (2) @(negedge clk_24m);
            if (rd_hit && i == 0) begin
                wb_addr = 2'd0;
                wb_we   = 1'b0;
                wb_cyc  = 1'b1;
            end
            spi_sck = 1'b0;
        end
        if (rd_hit) begin
            @(negedge clk_24m);
            n_checks++;
            if (wb_ack !== 1'b1) begin
                n_errors++;
                $display("FAIL hit_ack: got %b expected 1", wb_ack);
            end
            hit_data = wb_rdata;
            wb_cyc = 1'b0;
        end
        repeat (3) @(negedge clk_24m);
        n_checks++;
        if (q_miso.size() == 0) begin
            n_errors++;
            $display("FAIL miso_byte: got %h expected none queued", got);
        end else begin
            exp = q_miso.pop_front();
            if (got !== exp) begin
                n_errors++;
                $display("FAIL miso_byte: got %h expected %h", got, exp);
            end
        end
        if (rd_hit || !mdl_rx_valid) begin
            mdl_rx_valid = 1'b1;
            mdl_rx_data  = tx;
        end else begin
            mdl_ovr = 1'b1;
            if (mdl_ovr_cnt < 255) mdl_ovr_cnt++;
        end
        mdl_load();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] one;
        rst = 1'b1;
        mdl_reset();
        repeat (3) @(negedge clk_24m);
        one = {spi_miso, spi_miso_oe, wb_ack, 29'd0};
        n_checks++;
        if (one !== 32'h8000_0000 || wb_rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got miso/oe/ack=%b%b%b rdata=%h expected 100 0", spi_miso, spi_miso_oe, wb_ack, wb_rdata);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk_24m);
        wb_rd(2'd0, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL reset_rx: got %h expected 00000000", d); end
        wb_rd(2'd1, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL reset_tx: got %h expected 00000000", d); end
        wb_rd(2'd2, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL reset_status: got %h expected 00000000", d); end
        @(negedge clk_24m);
        n_checks++;
        if (wb_ack !== 1'b0 || wb_rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL idle_bus: got ack=%b rdata=%h expected 0 00000000", wb_ack, wb_rdata);
        end
        wb_wr(2'd3, 32'hFFFF_FFFF);
        wb_wr(2'd0, 32'h0000_00AB);
        wb_rd(2'd3, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL addr3_read: got %h expected 00000000", d); end
        wb_rd(2'd0, d);
        n_checks++;
        if (d !== 32'd0) begin n_errors++; $display("FAIL rx_write_ignored: got %h expected 00000000", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [31:0] h;
        wb_wr(2'd1, 32'h0000_00A5);
        wb_rd(2'd1, d);
        n_checks++;
        if (d !== 32'h8000_00A5) begin n_errors++; $display("FAIL tx_readback: got %h expected 800000a5", d); end
        cs_low();
        spi_byte(8'h3C, 1'b0, h);
        cs_high();
        wb_rd(2'd0, d);
        n_checks++;
        if (d !== 32'h8000_003C) begin n_errors++; $display("FAIL rx_first_read: got %h expected 8000003c", d); end
        wb_rd(2'd0, d);
        n_checks++;
        if (d !== 32'h0000_003C) begin n_errors++; $display("FAIL rx_second_read: got %h expected 0000003c", d); end
        wb_rd(2'd1, d);
        n_checks++;
        if (d !== {mdl_tx_full, 23'd0, mdl_tx_hold}) begin
            n_errors++;
            $display("FAIL tx_consumed: got %h expected %h", d, {mdl_tx_full, 23'd0, mdl_tx_hold});
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [31:0] h;
        logic [31:0] e;
        cs_low();
        spi_byte(8'h11, 1'b0, h);
        spi_byte(8'h22, 1'b0, h);
        cs_high();
        e = exp_status();
        wb_rd(2'd2, d);
        n_checks++;
        if (d !== e) begin n_errors++; $display("FAIL status_overrun: got %h expected %h", d, e); end
        e = exp_rx();
        wb_rd(2'd0, d);
        n_checks++;
        if (d !== e) begin n_errors++; $display("FAIL rx_after_drop: got %h expected %h", d, e); end
        wb_wr(2'd2, 32'h0000_0004);
        e = exp_status();
        wb_rd(2'd2, d);
        n_checks++;
        if (d !== e) begin n_errors++; $display("FAIL status_cleared: got %h expected %h", d, e); end
    endtask

    task automatic test_cs_abort();
        logic [31:0] d;
        logic [31:0] h;
        logic [31:0] e;
        cs_low();
        spi_bits(8'hA3, 5);
        cs_high();
        e = exp_status();
        wb_rd(2'd2, d);
        n_checks++;
        if (d !== e) begin n_errors++; $display("FAIL status_after_abort: got %h expected %h", d, e); end
        cs_low();
        spi_byte(8'h5A, 1'b0, h);
        cs_high();
        e = exp_rx();
        wb_rd(2'd0, d);
        n_checks++;
        if (d !== e || d !== 32'h8000_005A) begin
            n_errors++;
            $display("FAIL rx_after_abort: got %h expected 8000005a", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] h;
        logic [31:0] e_hit;
        logic [31:0] e;
        cs_low();
        spi_byte(8'h77, 1'b0, h);
        e_hit = exp_rx();
        spi_byte(8'h55, 1'b1, h);
        n_checks++;
        if (h !== e_hit) begin n_errors++; $display("FAIL hit_read_old: got %h expected %h", h, e_hit); end
        cs_high();
        e = exp_status();
        wb_rd(2'd2, d);
        n_checks++;
        if (d !== e) begin n_errors++; $display("FAIL hit_status: got %h expected %h", d, e); end
        e = exp_rx();
        wb_rd(2'd0, d);
        n_checks++;
        if (d !== e) begin n_errors++; $display("FAIL hit_new_byte: got %h expected %h", d, e); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic [31:0] h;
        logic [31:0] e;
        cs_low();
        spi_bits(8'hF0, 3);
        @(negedge clk_24m);
        rst = 1'b1;
        @(negedge clk_24m);
        n_checks++;
        if (spi_miso !== 1'b1 || spi_miso_oe !== 1'b0 || wb_ack !== 1'b0 || wb_rdata !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_midframe_outputs: got miso/oe/ack=%b%b%b rdata=%h expected 100 0", spi_miso, spi_miso_oe, wb_ack, wb_rdata);
        end
        repeat (2) @(negedge clk_24m);
        rst = 1'b0;
        mdl_reset();
        spi_bits(8'h96, 8);
        repeat (4) @(negedge clk_24m);
        n_checks++;
        if (spi_miso_oe !== 1'b0) begin n_errors++; $display("FAIL ignored_frame_oe: got %b expected 0", spi_miso_oe); end
        e = exp_status();
        wb_rd(2'd2, d);
        n_checks++;
        if (d !== e) begin n_errors++; $display("FAIL ignored_frame_status: got %h expected %h", d, e); end
        cs_high();
        cs_low();
        spi_byte(8'hC3, 1'b0, h);
        cs_high();
        e = exp_rx();
        wb_rd(2'd0, d);
        n_checks++;
        if (d !== e) begin n_errors++; $display("FAIL rx_after_rearm: got %h expected %h", d, e); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_cs_abort();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_wb.md
SPI_SLAVE_WB -- requirements
Module: spi_slave_wb

Interface
REQ-001 SHALL have parameter SYNC_LEN, default 2, meaning number of synchronizer flops on spi_sck/spi_mosi/spi_cs_n (legal range 2-3).
REQ-002 SHALL have ports: clk_24m  in  1  system clock; rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have SPI ports: spi_sck in 1, spi_mosi in 1, spi_cs_n in 1 (external master, mode 0, MSB first); spi_miso out 1; spi_miso_oe out 1 (pad tristate enable).
REQ-004 SHALL have Wishbone responder ports: wb_addr in 2, wb_wdata in 32, wb_rdata out 32, wb_we in 1, wb_cyc in 1, wb_ack out 1.

Function
REQ-005 SHALL pass spi_sck/spi_mosi/spi_cs_n through SYNC_LEN flops on clk_24m and detect SCK rise/fall and CS fall/rise from synchronized values; supported SCK <= 4 MHz.
REQ-006 SHALL use states IDLE (CS high or not armed) and XFER (CS low); CS fall while armed -> XFER; CS rise -> IDLE; armed set only after CS observed high.
REQ-007 On CS fall: bit_cnt<=0, tx_shift<=tx_hold if tx_full else 8'hFF, tx_full<=0, spi_miso_oe<=1, spi_miso<=tx_shift[7] value.
REQ-008 On SCK rise in XFER: rx_shift<={rx_shift[6:0],mosi}, bit_cnt increments modulo 8.
REQ-009 On SCK rise with bit_cnt==7: byte complete; next-byte tx_shift loaded per REQ-007 rule; if rx_valid==0 then rx_data<=byte, rx_valid<=1, else byte dropped (overrun) and rx_data unchanged.
REQ-010 On SCK fall in XFER: if bit_cnt!=0 shift tx_shift left, spi_miso<=new MSB; if bit_cnt==0 no shift (first bit already driven).
REQ-011 rx_valid SHALL be set within 1 clk_24m after the synchronized 8th SCK rise is detected (<= SYNC_LEN+2 clocks after pin edge).
REQ-012 CS rise mid-byte: partial byte discarded, bit_cnt<=0, spi_miso_oe<=0, rx_valid/rx_data unchanged.
REQ-013 wb_ack<=wb_cyc & ~wb_ack (one cycle latency, one-cycle pulse); wb_rdata SHALL be 0 whenever wb_ack is 0.
REQ-014 Address 0 (RX) read: {rx_valid,23'b0,rx_data}; the acked read clears rx_valid; writes ignored.
REQ-015 Address 1 (TX) write: tx_hold<=wb_wdata[7:0], tx_full<=1 (overwrites pending byte); read: {tx_full,23'b0,tx_hold}.
REQ-016 Address 2 (STATUS) read: bit0 tx_full, bit1 rx_valid, bit2 overrun, bit3 XFER state, [15:8] overrun count, others 0; address 3 reads 0, writes ignored.
REQ-017 Simultaneous byte complete and acked RX read: read returns old value, rx_valid remains 1 with new byte (set dominates, no overrun).
REQ-018 Simultaneous TX write and byte-boundary load: load uses pre-write tx_hold/tx_full; written byte stays pending with tx_full=1.

Reset
REQ-019 On rst: spi_miso=1, spi_miso_oe=0, wb_ack=0, wb_rdata=0, rx_valid=0, rx_data=0, tx_full=0, tx_hold=0, bit_cnt=0, armed=0, overrun=0, count=0, state IDLE.
REQ-020 If spi_cs_n is low when rst deasserts, the in-progress frame SHALL be ignored until CS goes high.

Configuration
REQ-021 Macro SPI_SLAVE_OVERRUN_EN defined: overrun sticky flag set on dropped byte, 8-bit count saturating at 255, writing 1 to STATUS bit2 clears both.
REQ-022 SPI_SLAVE_OVERRUN_EN undefined: STATUS bit2 and [15:8] read 0, STATUS writes ignored, drop behaviour of REQ-009 unchanged.

Verification
REQ-023 TX write 0xA5, CS low, master clocks 0x3C at 4 MHz -> MISO shifts 0xA5, RX read returns 0x8000003C, next RX read 0x0000003C.
REQ-024 No TX write, two-byte frame 0x11,0x22 without RX read -> MISO 0xFF,0xFF; RX holds 0x11; with macro STATUS bit2=1, count=1; clear write -> 0.
REQ-025 CS rise after 5 SCK clocks -> rx_valid stays 0, spi_miso_oe=0 within SYNC_LEN+2 clocks; next full frame received correctly.
REQ-026 RX read acked in the same cycle as byte 0x55 completes -> read returns previous byte, rx_valid=1, rx_data=0x55, no overrun.
REQ-027 rst asserted mid-frame with CS held low, released, frame continues -> no byte captured until CS high then low; all outputs at reset values during rst.
